cg_memory_copier: RTL
=====================

Name: cg_memory_copier

Overview:
- Memory-interface initiator (DMA-style block copy engine) that drives the read and write channels of cg_memory_interface toward a memory responder.
- Copies i_len consecutive words from a source word address to a destination word address.
- Read data is buffered in a small internal FIFO, so read and write channels run independently under backpressure.
- Sits between control logic (sequencer or CSR) and any cg_memory_interface memory.

Parameters:
DATA_WIDTH, 32, memory word width
ADDR_WIDTH, 32, word-address width of raddr/waddr
LEN_WIDTH, 16, width of transfer length and progress counter
FIFO_DEPTH, 4, read-data buffer depth and max read credits (power of 2, >=2)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_start  in  1  start pulse; sampled only in IDLE
i_src_addr  in  ADDR_WIDTH  first source word address
i_dst_addr  in  ADDR_WIDTH  first destination word address
i_len  in  LEN_WIDTH  number of words to copy
o_busy  out  1  high while state != IDLE
o_done  out  1  one-cycle completion pulse
o_words_done  out  LEN_WIDTH  words written in the current or last transfer
o_raddr  out  ADDR_WIDTH  read address
o_raddr_valid  out  1  read request valid
i_raddr_ready  in  1  read request accepted
i_rdata  in  DATA_WIDTH  read data
i_rdata_valid  in  1  read data valid
o_rdata_ready  out  1  read data accept
o_waddr  out  ADDR_WIDTH  write address
o_wdata  out  DATA_WIDTH  write data
o_wen  out  1  write enable, equal to o_wdata_valid
o_wdata_valid  out  1  write beat valid
i_wdata_ready  in  1  write beat accepted

Behaviour:
- Reset: state IDLE; all outputs 0; FIFO emptied; all counters and pointers 0. Reset mid-transfer aborts immediately with no further requests. Read data arriving after the abort is ignored (o_rdata_ready=0 in IDLE).
- FSM IDLE -> RUN -> DONE -> IDLE.
  - IDLE: on i_start, latch src, dst and len, and clear o_words_done. If len==0, go to DONE; otherwise go to RUN.
  - RUN: go to DONE in the cycle after the write beat that makes words_written==len.
  - DONE: o_done=1 for exactly one cycle, then IDLE.
  - i_start in RUN or DONE is ignored.
- Read channel (RUN only):
  - o_raddr_valid=1 iff reads_issued<len and (outstanding + fifo_count) < FIFO_DEPTH.
  - A request is accepted on o_raddr_valid && i_raddr_ready. On accept, o_raddr increments by 1 (mod 2^ADDR_WIDTH), reads_issued increments, and outstanding increments.
  - While valid and not accepted, o_raddr is held stable.
- Read data:
  - o_rdata_ready=1 throughout RUN; the credit rule guarantees FIFO space.
  - A beat is taken on i_rdata_valid && o_rdata_ready: push i_rdata and decrement outstanding.
  - Responses return in order, with any latency >=1 cycle.
  - A beat with outstanding==0 is dropped; this is a simulation assertion.
  - A push to a full FIFO is a simulation assertion.
- Write channel:
  - o_wdata_valid = o_wen = FIFO not empty, in RUN only.
  - o_wdata is the FIFO head; o_waddr is the dst pointer.
  - On o_wdata_valid && i_wdata_ready: pop the FIFO, increment the dst pointer (wrapping), and increment o_words_done.
  - o_wdata and o_waddr are held stable while valid and not accepted.
- FIFO timing:
  - A pushed word is visible at the head no earlier than the next cycle (registered, no bypass).
  - Simultaneous push and pop in one cycle: both occur and fifo_count is unchanged.
  - Simultaneous read accept and rdata receive: outstanding is unchanged.
- Latency, with a 1-cycle-latency, always-ready responder:
  - start sampled at cycle 0; first o_raddr_valid at cycle 1; first o_wen at cycle 3.
  - Steady state is 1 word/cycle.
  - o_done is asserted 1 cycle after the last write beat.
- Arithmetic: counters are LEN_WIDTH bits; max len is 2^LEN_WIDTH-1. The outstanding counter is $clog2(FIFO_DEPTH+1) bits. Addresses wrap modulo 2^ADDR_WIDTH.

Test Plan:
- len=0, start at cycle 0 -> o_busy=1 and o_done=1 at cycle 1; o_busy=0 at cycle 2; no raddr_valid or wen ever.
- len=8, src=0x10, dst=0x80, behavioural 1-cycle memory, write always ready, mem[0x10+i]=0xA0+i -> writes to 0x80..0x87 with data 0xA0..0xA7 on cycles 3..10; o_done at cycle 11; o_words_done=8.
- Same copy with i_wdata_ready=0 for cycles 3..15 -> exactly 4 reads issued, then o_raddr_valid=0; o_wdata/o_waddr stable; after release, all 8 words correct and in order.
- i_raddr_ready random 50% plus a responder with 1-3 cycle in-order read latency, len=100 -> destination equals source; outstanding + fifo_count never exceeds 4.
- src=0xFFFFFFFE, dst=0xFFFFFFFF, len=4 -> read addresses FFFFFFFE, FFFFFFFF, 0, 1; write addresses FFFFFFFF, 0, 1, 2.
- i_start pulsed mid-transfer -> ignored. Then i_rst asserted mid-transfer -> all outputs 0 the next cycle and late rdata ignored; a new start with len=3 completes correctly.

Source files
------------

// File: rtl/cg_memory_copier.sv
// Block-copy initiator: streams i_len words from a source to a destination address
// over decoupled read/write channels, buffering read data in a small credit-managed FIFO.
module cg_memory_copier #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_src_addr,
   input  logic [ADDR_WIDTH-1:0] i_dst_addr,
   input  logic [LEN_WIDTH-1:0]  i_len,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [LEN_WIDTH-1:0]  o_words_done,
   output logic [ADDR_WIDTH-1:0] o_raddr,
   output logic                  o_raddr_valid,
   input  logic                  i_raddr_ready,
   input  logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  i_rdata_valid,
   output logic                  o_rdata_ready,
   output logic [ADDR_WIDTH-1:0] o_waddr,
   output logic [DATA_WIDTH-1:0] o_wdata,
   output logic                  o_wen,
   output logic                  o_wdata_valid,
   input  logic                  i_wdata_ready
);
   // state  | meaning
   // S_IDLE | waiting for i_start, channels quiet
   // S_RUN  | issuing reads and draining the FIFO into writes
   // S_DONE | one-cycle completion pulse
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_raddr;
   logic [ADDR_WIDTH-1:0] r_waddr;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_reads_issued;
   logic [LEN_WIDTH-1:0]  r_words_done;
   logic [CW-1:0]         r_outstanding;
   logic [CW-1:0]         r_count;
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];

   logic          w_run;
   logic [CW:0]   w_credit_used;
   logic          w_raddr_valid;
   logic          w_raccept;
   logic          w_rtake;
   logic          w_push;
   logic          w_wvalid;
   logic          w_wbeat;

   assign w_run         = (r_state == S_RUN);
   // Credits cover both in-flight reads and buffered words, so a returning beat always has room.
   assign w_credit_used = {1'b0, r_outstanding} + {1'b0, r_count};
   assign w_raddr_valid = w_run && (r_reads_issued < r_len) &&
                          (w_credit_used < (CW+1)'(FIFO_DEPTH));
   assign w_raccept     = w_raddr_valid && i_raddr_ready;
   assign w_rtake       = w_run && i_rdata_valid;
   assign w_push        = w_rtake && (r_outstanding != '0);
   assign w_wvalid      = w_run && (r_count != '0);
   assign w_wbeat       = w_wvalid && i_wdata_ready;

   assign o_busy        = (r_state != S_IDLE);
   assign o_done        = (r_state == S_DONE);
   assign o_words_done  = r_words_done;
   assign o_raddr       = r_raddr;
   assign o_raddr_valid = w_raddr_valid;
   assign o_rdata_ready = w_run;
   assign o_waddr       = r_waddr;
   assign o_wdata       = w_wvalid ? r_fifo[r_rd_ptr] : '0;
   assign o_wen         = w_wvalid;
   assign o_wdata_valid = w_wvalid;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= S_IDLE;
         r_raddr        <= '0;
         r_waddr        <= '0;
         r_len          <= '0;
         r_reads_issued <= '0;
         r_words_done   <= '0;
         r_outstanding  <= '0;
         r_count        <= '0;
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_raddr        <= i_src_addr;
                  r_waddr        <= i_dst_addr;
                  r_len          <= i_len;
                  r_reads_issued <= '0;
                  r_words_done   <= '0;
                  r_outstanding  <= '0;
                  r_count        <= '0;
                  r_wr_ptr       <= '0;
                  r_rd_ptr       <= '0;
                  r_state        <= (i_len == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (w_raccept) begin
                  r_raddr        <= r_raddr + ADDR_WIDTH'(1);
                  r_reads_issued <= r_reads_issued + LEN_WIDTH'(1);
               end
               r_outstanding <= r_outstanding + CW'(w_raccept) - CW'(w_push);
               r_count       <= r_count + CW'(w_push) - CW'(w_wbeat);
               if (w_push)
                  r_wr_ptr <= r_wr_ptr + PW'(1);
               if (w_wbeat) begin
                  r_rd_ptr     <= r_rd_ptr + PW'(1);
                  r_waddr      <= r_waddr + ADDR_WIDTH'(1);
                  r_words_done <= r_words_done + LEN_WIDTH'(1);
                  if ((r_words_done + LEN_WIDTH'(1)) == r_len)
                     r_state <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push)
         r_fifo[r_wr_ptr] <= i_rdata;
   end

   a_no_orphan_beat : assert property (@(posedge i_clk) disable iff (i_rst)
      !(w_rtake && (r_outstanding == '0)));
   a_no_fifo_overflow : assert property (@(posedge i_clk) disable iff (i_rst)
      !(w_push && (r_count == CW'(FIFO_DEPTH))));

endmodule
